ground_rom_arbiter: RTL and testbench
=====================================

# ground_rom_arbiter

Shares the single-port ground-texture ROM (128×128 pixels, 14-bit address, 12-bit RGB, one-cycle registered read) between several ground/platform draw units. Each requester presents an address and waits for a grant. The arbiter drives the ROM address and returns the pixel to the correct requester with a fixed, known latency. It sits between the draw units and `img_ground_rom` in the rendering pipeline, and is the only block that drives the ROM address.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 14: ROM address width, `{y[6:0], x[6:0]}`.
- `RGB_W`, 12: pixel width.

Ports:
- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `req`, in, `N_REQ`: request per requester. The requester holds it high together with its address until `gnt` is seen.
- `req_addr`, in, `N_REQ*ADDR_W`: packed addresses. Requester i uses bits `[i*ADDR_W +: ADDR_W]`.
- `lock`, in, `N_REQ`: burst-hold request. Honoured only when `GROUND_ARB_LOCK_EN` is defined.
- `gnt`, out, `N_REQ`: registered, one-hot or zero. The requester's address is consumed in this cycle.
- `rom_addr`, out, `ADDR_W`: registered address to the ROM.
- `rom_rgb`, in, `RGB_W`: ROM read data, valid one cycle after `rom_addr`.
- `rgb_out`, out, `RGB_W`: registered pixel, broadcast to all requesters.
- `rgb_valid`, out, `N_REQ`: registered, one-hot or zero. Marks the owner of `rgb_out`.

## Operation
- Round-robin arbitration over `req`. Priority starts at `last_winner+1` modulo `N_REQ` and searches upward with wrap-around.
- Per cycle:
  - If any `req` bit is set: pick the winner, register `gnt` = onehot(winner), register `rom_addr` = winner's address, push the winner onto the tag pipe, and update `last_winner`.
  - Otherwise: `gnt`=0, `rom_addr` holds its previous value, and a "no-op" tag is pushed.
- Tag pipe has 2 stages, each holding a valid bit and a `$clog2(N_REQ)` index. The stage-2 tag drives `rgb_valid` in the same cycle that `rgb_out` is registered from `rom_rgb`.
- Throughput: one grant per cycle, back-to-back, with no bubbles.
- A requester must deassert `req` in the cycle after it sees `gnt`, or present a new address. A still-asserted `req` is treated as a new request.
- Boundaries:
  - Single requester: granted every cycle.
  - All requesters active: strict rotation 0,1,2,3,0,...
  - A request arriving in the same cycle as the current winner's release competes normally.
  - `last_winner` wraps from `N_REQ-1` to 0.
  - Address values are passed through unmodified, with no range check.
- Reset values:
  - `gnt`=0, `rgb_valid`=0, `rom_addr`=0, `rgb_out`=0.
  - `last_winner`=`N_REQ-1`, so requester 0 has first priority.
  - Tag pipe cleared.
- Reset mid-operation: in-flight tags are discarded and no `rgb_valid` pulse occurs after reset for pre-reset grants.

## Timing
- `req` sampled at edge t → `gnt` and `rom_addr` valid in cycle t+1 → ROM data in t+2 → `rgb_out`/`rgb_valid` in t+3.
- Fixed latency: 2 cycles from `gnt` to `rgb_valid`, 3 cycles from the request edge.
- No combinational path from any input to any output.

## Configuration
- `GROUND_ARB_LOCK_EN` defined:
  - If the current winner still has both `req` and `lock` high, it is granted again next cycle regardless of rotation. This supports a contiguous pixel run on a scanline.
  - Rotation resumes from `winner+1` once `lock` or `req` drops.
  - The lock is capped at 128 consecutive grants (one texture row) by a 7-bit counter. After the cap the winner is forced to release for at least one arbitration round.
- Not defined: the `lock` port exists but is ignored, and the lock counter is not built. Behaviour is pure round-robin.

## Structure
- Package `ground_arb_pkg`: `N_REQ`, `ADDR_W`, `RGB_W`, `ROM_LAT`=1, `LOCK_MAX`=128, and the tag struct typedef `{valid, idx}`.
- Sub-module `rr_pick`: purely combinational. Takes the `req` vector and the start index, returns a one-hot winner and a found flag. It is used once by the arbiter.
- The arbiter holds all state: `last_winner`, the tag pipe, the output registers, and the optional lock counter.

## Test plan
- Reset, then `req`=0 for 10 cycles → `gnt`=0, `rgb_valid`=0, `rom_addr`=0 throughout.
- `req`=4'b0010 with address `0x0123`, ROM model returns `addr[11:0]` → `gnt`=4'b0010 at t+1, `rom_addr`=`0x0123`, `rgb_out`=`0x123` with `rgb_valid`=4'b0010 at t+3.
- `req`=4'b1111 held for 8 cycles → `gnt` sequence 0001,0010,0100,1000,0001,... and each `rgb_valid` lags its `gnt` by 2 cycles.
- `rst` pulsed 1 cycle after two grants → no `rgb_valid` is asserted afterwards, and the next grant goes to requester 0.
- With `GROUND_ARB_LOCK_EN`: `req`=4'b0101, `lock`=4'b0001 → requester 0 granted 128 consecutive cycles, then requester 2 receives the next grant.
- Without the macro, same stimulus as the previous line → `gnt` alternates 0001/0100.

Source files
------------

// File: rtl/ground_rom_arbiter_pkg.sv
// Shared constants and tag type for the ground-texture ROM arbiter.
// GROUND_ARB_LOCK_EN enables the burst-hold lock path in the arbiter.
package ground_arb_pkg;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned RGB_W    = 12;
    localparam int unsigned ROM_LAT  = 1;
    localparam int unsigned LOCK_MAX = 128;

    // Tag index is sized for the largest legal requester count so one
    // typedef serves every parameterisation of the arbiter.
    localparam int unsigned MAX_REQ    = 8;
    localparam int unsigned TAG_IDX_W  = $clog2(MAX_REQ);
    localparam int unsigned LOCK_CNT_W = $clog2(LOCK_MAX);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [TAG_IDX_W-1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
        logic [TAG_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | TAG_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ground_rom_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above start_i,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = ground_arb_pkg::N_REQ,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             found_o
);

    logic [IDX_W-1:0] idx;
    logic             hit;

    always_comb begin
        gnt_o = '0;
        hit   = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((32'(start_i) + k) % N_REQ);
            if (!hit && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                hit        = 1'b1;
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/ground_rom_arbiter.sv
// Round-robin arbiter sharing the ground-texture ROM between draw units.
// Define GROUND_ARB_LOCK_EN to honour the per-requester burst lock.
module ground_rom_arbiter #(
    parameter int unsigned N_REQ  = ground_arb_pkg::N_REQ,
    parameter int unsigned ADDR_W = ground_arb_pkg::ADDR_W,
    parameter int unsigned RGB_W  = ground_arb_pkg::RGB_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ-1:0]         lock,
    output logic [N_REQ-1:0]         gnt,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [RGB_W-1:0]         rom_rgb,
    output logic [RGB_W-1:0]         rgb_out,
    output logic [N_REQ-1:0]         rgb_valid
);

    import ground_arb_pkg::*;

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned PIPE_D = ROM_LAT + 1;

    logic [IDX_W-1:0]     last_winner_q, last_winner_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [RGB_W-1:0]     rgb_out_q;
    logic [N_REQ-1:0]     rgb_valid_q, rgb_valid_d;
    tag_t                 tag_q [PIPE_D];
    tag_t                 tag_d;

    logic [IDX_W-1:0]     start_idx;
    logic [N_REQ-1:0]     pick_oh;
    logic                 pick_found;
    logic [N_REQ-1:0]     win_oh;
    logic                 win_found;
    logic [TAG_IDX_W-1:0] win_idx;

    always_comb begin
        start_idx = (last_winner_q == IDX_W'(N_REQ - 1)) ? '0 : last_winner_q + 1'b1;
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .start_i (start_idx),
        .gnt_o   (pick_oh),
        .found_o (pick_found)
    );

`ifdef GROUND_ARB_LOCK_EN
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  hold;

    // Counter holds grants-so-far minus one, so the cap lands on grant LOCK_MAX.
    always_comb begin
        win_oh     = pick_oh;
        win_found  = pick_found;
        lock_cnt_d = '0;
        hold       = (|(gnt_q & req & lock)) && (lock_cnt_q != LOCK_CNT_W'(LOCK_MAX - 1));
        if (hold) begin
            win_oh     = gnt_q;
            win_found  = 1'b1;
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;

    always_comb begin
        unused_lock = ^lock;
        win_oh      = pick_oh;
        win_found   = pick_found;
    end
`endif

    always_comb begin
        win_idx       = onehot_idx(MAX_REQ'(win_oh));
        gnt_d         = win_oh;
        last_winner_d = win_found ? IDX_W'(win_idx) : last_winner_q;
        rom_addr_d    = rom_addr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                rom_addr_d = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        tag_d.valid = win_found;
        tag_d.idx   = win_idx;
        rgb_valid_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rgb_valid_d[i] = tag_q[PIPE_D-1].valid && (tag_q[PIPE_D-1].idx == TAG_IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= IDX_W'(N_REQ - 1);
            gnt_q         <= '0;
            rom_addr_q    <= '0;
            rgb_out_q     <= '0;
            rgb_valid_q   <= '0;
            for (int unsigned k = 0; k < PIPE_D; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            last_winner_q <= last_winner_d;
            gnt_q         <= gnt_d;
            rom_addr_q    <= rom_addr_d;
            rgb_out_q     <= rom_rgb;
            rgb_valid_q   <= rgb_valid_d;
            tag_q[0]      <= tag_d;
            for (int unsigned k = 1; k < PIPE_D; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        gnt       = gnt_q;
        rom_addr  = rom_addr_q;
        rgb_out   = rgb_out_q;
        rgb_valid = rgb_valid_q;
    end

endmodule

// File: tb/tb_ground_rom_arbiter.sv
// Scoreboard bench for ground_rom_arbiter; lock expectations follow
// whether GROUND_ARB_LOCK_EN is defined.
module tb_ground_rom_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 14;
    localparam int unsigned CW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    lock = '0;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [CW-1:0]   rom_rgb = '0;
    logic [CW-1:0]   rgb_out;
    logic [N-1:0]    rgb_valid;

    typedef struct {
        logic [N-1:0]  valid;
        logic [CW-1:0] rgb;
        int unsigned   cyc;
    } exp_t;

    exp_t        sb_q [$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [AW-1:0] a [N];

    ground_rom_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .RGB_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .lock      (lock),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_rgb   (rom_rgb),
        .rgb_out   (rgb_out),
        .rgb_valid (rgb_valid)
    );

    always #5 clk = ~clk;

    // ROM model: one-cycle registered read returning the low address bits.
    always @(posedge clk) rom_rgb <= rom_addr[CW-1:0];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rgb_valid !== '0) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL rgb_unexpected cyc=%0d valid=%b rgb=%h required valid=0", cyc, rgb_valid, rgb_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (rgb_valid !== e.valid || rgb_out !== e.rgb || cyc !== e.cyc + 2) begin
                    bad++;
                    $display("FAIL rgb_out cyc=%0d got valid=%b rgb=%h required valid=%b rgb=%h at cyc=%0d",
                             cyc, rgb_valid, rgb_out, e.valid, e.rgb, e.cyc + 2);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc + 2 == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            bad++;
            $display("FAIL rgb_missing cyc=%0d got valid=%b required valid=%b rgb=%h", cyc, rgb_valid, e.valid, e.rgb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] v, input logic [AW-1:0] addr);
        exp_t e;
        e.valid = v;
        e.rgb   = addr[CW-1:0];
        e.cyc   = cyc;
        sb_q.push_back(e);
    endtask

    task automatic set_addrs();
        for (int i = 0; i < N; i++) begin
            a[i] = AW'($urandom_range(0, (1 << AW) - 1));
            req_addr[i*AW +: AW] = a[i];
        end
    endtask

    task automatic apply_reset();
        req = '0;
        lock = '0;
        rst = 1'b1;
        sb_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '0;
        lock = '0;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (gnt !== '0 || rgb_valid !== '0 || rom_addr !== '0 || rgb_out !== '0) begin
            bad++;
            $display("FAIL reset_regs gnt=%b valid=%b rom_addr=%h rgb=%h required all zero", gnt, rgb_valid, rom_addr, rgb_out);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (gnt !== '0 || rgb_valid !== '0 || rom_addr !== '0) begin
                bad++;
                $display("FAIL idle_after_reset k=%0d gnt=%b valid=%b rom_addr=%h required all zero", k, gnt, rgb_valid, rom_addr);
            end
        end
    endtask

    task automatic test_single();
        set_addrs();
        a[1] = 14'h0123;
        req_addr[1*AW +: AW] = a[1];
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010 || rom_addr !== 14'h0123) begin
            bad++;
            $display("FAIL single_grant gnt=%b rom_addr=%h required gnt=0010 rom_addr=0123", gnt, rom_addr);
        end
        push_exp(4'b0010, 14'h0123);
        req = '0;
        tick();
        total++;
        if (gnt !== '0 || rom_addr !== 14'h0123) begin
            bad++;
            $display("FAIL idle_hold gnt=%b rom_addr=%h required gnt=0000 rom_addr=0123", gnt, rom_addr);
        end
        repeat (3) tick();
        req = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            set_addrs();
            tick();
            total++;
            if (gnt !== 4'b1000 || rom_addr !== a[3]) begin
                bad++;
                $display("FAIL single_held k=%0d gnt=%b rom_addr=%h required gnt=1000 rom_addr=%h", k, gnt, rom_addr, a[3]);
            end
            push_exp(4'b1000, a[3]);
        end
        req = '0;
        repeat (4) tick();
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_g;
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            set_addrs();
            tick();
            exp_g = N'(1) << (k % N);
            total++;
            if (gnt !== exp_g || rom_addr !== a[k % N]) begin
                bad++;
                $display("FAIL rotation k=%0d gnt=%b rom_addr=%h required gnt=%b rom_addr=%h", k, gnt, rom_addr, exp_g, a[k % N]);
            end
            push_exp(exp_g, a[k % N]);
        end
        req = '0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            set_addrs();
            tick();
            push_exp(gnt, rom_addr);
        end
        req = '0;
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (rgb_valid !== '0 || gnt !== '0) begin
                bad++;
                $display("FAIL reset_mid_quiet k=%0d valid=%b gnt=%b required 0", k, rgb_valid, gnt);
            end
        end
        set_addrs();
        req = 4'b1111;
        tick();
        total++;
        if (gnt !== 4'b0001 || rom_addr !== a[0]) begin
            bad++;
            $display("FAIL reset_mid_first gnt=%b rom_addr=%h required gnt=0001 rom_addr=%h", gnt, rom_addr, a[0]);
        end
        push_exp(4'b0001, a[0]);
        req = '0;
        repeat (4) tick();
    endtask

    task automatic test_lock();
        logic [N-1:0] exp_g;
        apply_reset();
        set_addrs();
        req = 4'b0101;
        lock = 4'b0001;
        for (int k = 0; k < 130; k++) begin
`ifdef GROUND_ARB_LOCK_EN
            exp_g = (k == 128) ? 4'b0100 : 4'b0001;
`else
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
            tick();
            total++;
            if (gnt !== exp_g || rom_addr !== (exp_g[0] ? a[0] : a[2])) begin
                bad++;
                $display("FAIL lock k=%0d gnt=%b rom_addr=%h required gnt=%b", k, gnt, rom_addr, exp_g);
            end
            push_exp(exp_g, exp_g[0] ? a[0] : a[2]);
        end
        req = '0;
        lock = '0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_reset_mid();
        test_lock();
        repeat (3) tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
